// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one word-wide unified memory between a 4-beat icache fill port and a single-word dcache port.
module mem_arbiter #(
  parameter bit DCACHE_FIRST = 1'b1
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         I_READ,
  input  logic [5:0]   I_ADDRESS,
  output logic [127:0] I_READDATA,
  output logic         I_BUSYWAIT,
  input  logic         D_READ,
  input  logic         D_WRITE,
  input  logic [5:0]   D_ADDRESS,
  input  logic [31:0]  D_WRITEDATA,
  output logic [31:0]  D_READDATA,
  output logic         D_BUSYWAIT,
  output logic         MEM_READ,
  output logic         MEM_WRITE,
  output logic [8:0]   MEM_ADDRESS,
  output logic [31:0]  MEM_WRITEDATA,
  input  logic [31:0]  MEM_READDATA,
  input  logic         MEM_BUSYWAIT
);
  typedef enum logic [2:0] {IDLE, I_REQ, I_GAP, I_DONE, D_REQ, D_DONE} state_t;
  state_t state, state_n;
  logic [1:0] beat;
  logic [5:0] i_addr, d_addr;
  logic [31:0] wdata;
  logic d_wr, d_req, grant_d;
  assign d_req = D_READ | D_WRITE;
  assign grant_d = d_req & (DCACHE_FIRST | ~I_READ);
  assign I_BUSYWAIT = I_READ & (state != I_DONE);
  assign D_BUSYWAIT = d_req & (state != D_DONE);
  // REQ states are only ever entered from IDLE or I_GAP, so being in REQ at an edge
  // means the strobe was already high for the whole preceding cycle
  assign MEM_READ = (state == I_REQ) | ((state == D_REQ) & ~d_wr);
  assign MEM_WRITE = (state == D_REQ) & d_wr;
  assign MEM_ADDRESS = (state == I_REQ) ? {1'b0, i_addr, beat} :
                       (state == D_REQ) ? {3'b100, d_addr} : 9'd0;
  assign MEM_WRITEDATA = MEM_WRITE ? wdata : 32'd0;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = grant_d ? D_REQ : I_READ ? I_REQ : IDLE;
      I_REQ:   state_n = MEM_BUSYWAIT ? I_REQ : (beat == 2'd3) ? I_DONE : I_GAP;
      I_GAP:   state_n = I_REQ;
      D_REQ:   state_n = MEM_BUSYWAIT ? D_REQ : D_DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      beat <= 2'd0;
      i_addr <= 6'd0;
      d_addr <= 6'd0;
      d_wr <= 1'b0;
      wdata <= 32'd0;
      I_READDATA <= 128'd0;
      D_READDATA <= 32'd0;
    end else begin
      state <= state_n;
      if (state == IDLE && state_n == D_REQ) begin
        d_addr <= D_ADDRESS;
        d_wr <= D_WRITE;
        wdata <= D_WRITEDATA;
      end
      if (state == IDLE && state_n == I_REQ) begin
        i_addr <= I_ADDRESS;
        beat <= 2'd0;
      end
      if (state == I_REQ && !MEM_BUSYWAIT) begin
        I_READDATA[{beat, 5'd0} +: 32] <= MEM_READDATA;
        if (beat != 2'd3) beat <= beat + 2'd1;
      end
      if (state == D_REQ && !MEM_BUSYWAIT && !d_wr) D_READDATA <= MEM_READDATA;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter with both grant priorities against a variable-latency memory model.
module tb_mem_arbiter;
  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;
  logic [1:0] i_read, d_read, d_write, i_bw, d_bw, m_rd, m_wr, m_bw;
  logic [5:0] i_addr [2], d_addr [2];
  logic [31:0] d_wdata [2], d_rdata [2], m_wdata [2], m_rdata [2];
  logic [127:0] i_rdata [2];
  logic [8:0] m_addr [2];
  logic [31:0] mem [2][512];
  logic [8:0] lg [2][64];
  int lt [2][64];
  int ln [2] = '{0, 0};
  int cnt [2] = '{0, 0};
  int cyc = 0;
  int nlat;
  logic mem_init;
  int total = 0, bad = 0;
  typedef struct {
    int kind;
    logic [5:0] addr;
    logic [31:0] wd;
    int n;
    logic [127:0] exp_data;
    logic [8:0] exp_addr;
    int exp_lat;
  } vec_t;
  vec_t vt [9];
  logic [127:0] ilast;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_arbiter #(.DCACHE_FIRST(g == 0)) u_dut (
      .CLK(CLK), .RESET(RESET),
      .I_READ(i_read[g]), .I_ADDRESS(i_addr[g]), .I_READDATA(i_rdata[g]), .I_BUSYWAIT(i_bw[g]),
      .D_READ(d_read[g]), .D_WRITE(d_write[g]), .D_ADDRESS(d_addr[g]), .D_WRITEDATA(d_wdata[g]),
      .D_READDATA(d_rdata[g]), .D_BUSYWAIT(d_bw[g]),
      .MEM_READ(m_rd[g]), .MEM_WRITE(m_wr[g]), .MEM_ADDRESS(m_addr[g]), .MEM_WRITEDATA(m_wdata[g]),
      .MEM_READDATA(m_rdata[g]), .MEM_BUSYWAIT(m_bw[g])
    );
    // busy rises combinationally with the strobe and clears in the strobe's nlat-th cycle
    assign m_bw[g] = (m_rd[g] | m_wr[g]) && (cnt[g] + 1 < nlat);
    assign m_rdata[g] = mem[g][m_addr[g]];
  end
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 2; k++) begin
      cnt[k] <= (m_rd[k] | m_wr[k]) ? cnt[k] + 1 : 0;
      if ((m_rd[k] | m_wr[k]) && !m_bw[k]) begin
        if (m_wr[k]) mem[k][m_addr[k]] <= m_wdata[k];
        lg[k][ln[k] % 64] <= m_addr[k];
        lt[k][ln[k] % 64] <= cyc;
        ln[k] <= ln[k] + 1;
      end
      if (mem_init) for (int a = 0; a < 512; a++) mem[k][a] <= a + 32'h94;
    end
  end
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic run_vec(input int k, input vec_t v);
    int lat, n0;
    nlat = v.n;
    @(negedge CLK);
    n0 = ln[k];
    if (v.kind == 0) begin
      i_read[k] = 1'b1;
      i_addr[k] = v.addr;
    end else begin
      d_write[k] = (v.kind == 1);
      d_read[k] = (v.kind == 2);
      d_addr[k] = v.addr;
      d_wdata[k] = v.wd;
    end
    #1;
    lat = 1;
    while (((v.kind == 0) ? i_bw[k] : d_bw[k]) && lat < 200) begin
      @(negedge CLK);
      lat++;
    end
    chk("latency", 128'(lat), 128'(v.exp_lat));
    if (v.kind == 0) begin
      chk("i_readdata", i_rdata[k], v.exp_data);
      ilast = v.exp_data;
    end else begin
      chk("d_readdata", {96'd0, d_rdata[k]}, v.exp_data);
      chk("i_untouched", i_rdata[k], ilast);
    end
    i_read[k] = 1'b0;
    d_read[k] = 1'b0;
    d_write[k] = 1'b0;
    chk("beats", 128'(ln[k] - n0), (v.kind == 0) ? 128'd4 : 128'd1);
    chk("addr0", {119'd0, lg[k][n0 % 64]}, {119'd0, v.exp_addr});
    if (v.kind == 0)
      for (int b = 1; b < 4; b++) begin
        chk("beat_addr", {119'd0, lg[k][(n0 + b) % 64]}, {119'd0, v.exp_addr + 9'(b)});
        chk("beat_gap", 128'(lt[k][(n0 + b) % 64] - lt[k][(n0 + b - 1) % 64]), 128'(v.n + 1));
      end
    @(posedge CLK);
  endtask
  initial begin
    int dd [2], id [2], n0 [2], c;
    logic stall_ok;
    vt[0] = '{0, 6'h03, 32'h0, 1, 128'h000000A3_000000A2_000000A1_000000A0, 9'h00C, 9};
    vt[1] = '{1, 6'h05, 32'hDEADBEEF, 1, 128'h0, 9'h105, 3};
    vt[2] = '{2, 6'h05, 32'h0, 1, 128'hDEADBEEF, 9'h105, 3};
    vt[3] = '{2, 6'h05, 32'h0, 7, 128'hDEADBEEF, 9'h105, 9};
    vt[4] = '{2, 6'h02, 32'h0, 1, 128'h196, 9'h102, 3};
    vt[5] = '{0, 6'h01, 32'h0, 2, 128'h0000009B_0000009A_00000099_00000098, 9'h004, 13};
    vt[6] = '{1, 6'h3F, 32'h12345678, 3, 128'h196, 9'h13F, 5};
    vt[7] = '{2, 6'h3F, 32'h0, 3, 128'h12345678, 9'h13F, 5};
    vt[8] = '{0, 6'h3F, 32'h0, 1, 128'h00000193_00000192_00000191_00000190, 9'h0FC, 9};
    RESET = 1'b1;
    mem_init = 1'b1;
    nlat = 1;
    ilast = 128'd0;
    i_read = 2'b0;
    d_read = 2'b0;
    d_write = 2'b0;
    for (int k = 0; k < 2; k++) begin
      i_addr[k] = 6'd0;
      d_addr[k] = 6'd0;
      d_wdata[k] = 32'd0;
    end
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    mem_init = 1'b0;
    chk("reset_ctl", {119'd0, m_rd, m_wr, i_bw, d_bw}, 128'd0);
    chk("reset_mem", {87'd0, m_addr[0], m_wdata[0]}, 128'd0);
    chk("reset_i", i_rdata[0], 128'd0);
    chk("reset_d", {96'd0, d_rdata[0]}, 128'd0);
    for (int i = 0; i < 9; i++) run_vec(0, vt[i]);
    // reset while beat 2 of a fill is on the bus
    nlat = 1;
    @(negedge CLK);
    i_read[0] = 1'b1;
    i_addr[0] = 6'h03;
    c = 0;
    while (!(m_rd[0] && m_addr[0] == 9'h00E) && c < 50) begin
      @(negedge CLK);
      c++;
    end
    chk("reach_beat2", 128'(c < 50), 128'd1);
    RESET = 1'b1;
    i_read[0] = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    chk("rst_mem_read", {127'd0, m_rd[0]}, 128'd0);
    chk("rst_i_data", i_rdata[0], 128'd0);
    chk("rst_d_data", {96'd0, d_rdata[0]}, 128'd0);
    chk("rst_i_bw", {127'd0, i_bw[0]}, 128'd0);
    ilast = 128'd0;
    run_vec(0, vt[0]);
    // simultaneous requests on both priority variants
    nlat = 1;
    @(negedge CLK);
    stall_ok = 1'b1;
    for (int k = 0; k < 2; k++) begin
      n0[k] = ln[k];
      dd[k] = -1;
      id[k] = -1;
      i_read[k] = 1'b1;
      i_addr[k] = 6'h01;
      d_read[k] = 1'b1;
      d_addr[k] = 6'h02;
    end
    #1;
    c = 0;
    while ((i_read != 2'b0 || d_read != 2'b0) && c < 40) begin
      if (d_read[0] && !i_bw[0]) stall_ok = 1'b0;
      for (int k = 0; k < 2; k++) begin
        if (d_read[k] && !d_bw[k]) begin
          dd[k] = c;
          chk("sim_d_data", {96'd0, d_rdata[k]}, 128'h196);
          d_read[k] = 1'b0;
        end
        if (i_read[k] && !i_bw[k]) begin
          id[k] = c;
          chk("sim_i_data", i_rdata[k], 128'h0000009B_0000009A_00000099_00000098);
          i_read[k] = 1'b0;
        end
      end
      @(negedge CLK);
      c++;
    end
    chk("sim_i_stalled", {127'd0, stall_ok}, 128'd1);
    chk("dfirst_d_done", 128'(dd[0]), 128'd2);
    chk("dfirst_i_done", 128'(id[0]), 128'd11);
    chk("ifirst_i_done", 128'(id[1]), 128'd8);
    chk("ifirst_d_done", 128'(dd[1]), 128'd11);
    chk("dfirst_order", {110'd0, lg[0][n0[0] % 64], lg[0][(n0[0] + 1) % 64]}, {110'd0, 9'h102, 9'h004});
    chk("ifirst_order", {110'd0, lg[1][n0[1] % 64], lg[1][(n0[1] + 4) % 64]}, {110'd0, 9'h004, 9'h102});
    @(posedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
